// File: rtl/add_accumulator.sv
// Stream accumulator: sums COUNT operands with a WIDTH-bit wrap-around adder and
// presents the sum plus a sticky carry through a valid/ready output handshake.
module add_accumulator #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned COUNT = 4
) (
    input  logic             c,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             busy
);

    localparam int unsigned CntW = (COUNT < 1) ? 1 : $clog2(COUNT + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(COUNT - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic              carry_q, carry_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [WIDTH:0]    sum_full;
    logic              in_xfer;
    logic              out_xfer;
    logic              last_beat;

    assign in_ready  = rst_n && (state_q != StDone);
    assign out_valid = (state_q == StDone);
    assign out_sum   = acc_q;
    assign out_carry = carry_q;
    assign busy      = (state_q == StAccum) || (state_q == StDone);

    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign sum_full  = {1'b0, acc_q} + {1'b0, in_data};
    // In IDLE cnt_q is zero, so COUNT==1 completes on the very first beat.
    assign last_beat = (cnt_q == LastCnt);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;

        if (clr) begin
            state_d = StIdle;
            acc_d   = '0;
            carry_d = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle, StAccum: begin
                    if (in_xfer) begin
                        acc_d   = sum_full[WIDTH-1:0];
                        carry_d = carry_q | sum_full[WIDTH];
                        cnt_d   = cnt_q + 1'b1;
                        state_d = last_beat ? StDone : StAccum;
                    end
                end
                StDone: begin
                    if (out_xfer) begin
                        state_d = StIdle;
                        acc_d   = '0;
                        carry_d = 1'b0;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    acc_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_add_accumulator.sv
// Directed bench for add_accumulator: a COUNT=4 instance for the main scenarios and a
// COUNT=1 instance for single-beat batches.
module tb_add_accumulator;

    logic       c;
    logic       rst_n;

    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_sum;
    logic       out_carry;
    logic       busy;

    logic       b_clr;
    logic       b_in_valid;
    logic       b_in_ready;
    logic [3:0] b_in_data;
    logic       b_out_valid;
    logic       b_out_ready;
    logic [3:0] b_out_sum;
    logic       b_out_carry;
    logic       b_busy;

    int n_checks;
    int n_errors;

    add_accumulator #(.WIDTH(4), .COUNT(4)) u_dut (
        .c         (c),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .busy      (busy)
    );

    add_accumulator #(.WIDTH(4), .COUNT(1)) u_dut_c1 (
        .c         (c),
        .rst_n     (rst_n),
        .clr       (b_clr),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_sum   (b_out_sum),
        .out_carry (b_out_carry),
        .busy      (b_busy)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Feeds four operands (d0 first) with `gap` idle cycles between beats; returns in DONE.
    task automatic run_batch(input string tag, input logic [3:0] d0, input logic [3:0] d1,
                             input logic [3:0] d2, input logic [3:0] d3,
                             input logic ordy, input int gap);
        logic [3:0] ops [4];
        ops[0] = d0;
        ops[1] = d1;
        ops[2] = d2;
        ops[3] = d3;
        out_ready = ordy;
        for (int i = 0; i < 4; i++) begin
            check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
            in_valid = 1'b1;
            in_data  = ops[i];
            tick();
            in_valid = 1'b0;
            in_data  = 4'hA;
            if (i < 3) begin
                check({tag, "_no_early_valid"}, {31'd0, out_valid}, 32'd0);
                for (int g = 0; g < gap; g++) begin
                    tick();
                    check({tag, "_gap_busy"}, {31'd0, busy}, 32'd1);
                    check({tag, "_gap_valid"}, {31'd0, out_valid}, 32'd0);
                end
            end
        end
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_idle_sum"}, {28'd0, out_sum}, 32'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        clr         = 1'b0;
        in_valid    = 1'b0;
        in_data     = 4'd0;
        out_ready   = 1'b0;
        b_clr       = 1'b0;
        b_in_valid  = 1'b0;
        b_in_data   = 4'd0;
        b_out_ready = 1'b1;

        // Reset state
        tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum", {28'd0, out_sum}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        expect_idle("post_rst");

        // Back-to-back 1,2,3,4 with out_ready=1
        run_batch("b2b", 4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 0);
        check("b2b_sum", {28'd0, out_sum}, 32'd10);
        check("b2b_carry", {31'd0, out_carry}, 32'd0);
        tick();
        expect_idle("b2b");

        // Wrap-around with sticky carry, then a clean batch
        run_batch("wrap", 4'd15, 4'd1, 4'd0, 4'd0, 1'b1, 0);
        check("wrap_sum", {28'd0, out_sum}, 32'd0);
        check("wrap_carry", {31'd0, out_carry}, 32'd1);
        tick();
        run_batch("ones", 4'd1, 4'd1, 4'd1, 4'd1, 1'b1, 0);
        check("ones_sum", {28'd0, out_sum}, 32'd4);
        check("ones_carry", {31'd0, out_carry}, 32'd0);
        tick();

        // Hold result under backpressure; offered input must be ignored
        run_batch("hold", 4'd2, 4'd4, 4'd6, 4'd8, 1'b0, 0);
        in_valid = 1'b1;
        in_data  = 4'd7;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_sum", {28'd0, out_sum}, 32'd4);
            check("hold_carry", {31'd0, out_carry}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        expect_idle("hold");

        // clr after two beats, then a fresh batch
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'd7;
        tick();
        tick();
        in_valid = 1'b0;
        check("clr_pre_busy", {31'd0, busy}, 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        expect_idle("clr_accum");
        run_batch("after_clr", 4'd5, 4'd5, 4'd5, 4'd5, 1'b0, 0);
        check("after_clr_sum", {28'd0, out_sum}, 32'd4);
        check("after_clr_carry", {31'd0, out_carry}, 32'd1);
        // clr coincident with output handshake drops the result
        clr       = 1'b1;
        out_ready = 1'b1;
        tick();
        expect_idle("clr_done");
        check("clr_done_carry", {31'd0, out_carry}, 32'd0);
        // clr coincident with an input transfer drops the operand
        in_valid = 1'b1;
        in_data  = 4'd9;
        tick();
        in_valid = 1'b0;
        clr      = 1'b0;
        expect_idle("clr_xfer");

        // Gaps of 3 idle cycles between beats
        run_batch("gaps", 4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 3);
        check("gaps_sum", {28'd0, out_sum}, 32'd10);
        check("gaps_carry", {31'd0, out_carry}, 32'd0);
        tick();

        // Asynchronous reset during ACCUM
        in_valid = 1'b1;
        in_data  = 4'd6;
        tick();
        tick();
        in_valid = 1'b0;
        check("arst_pre_sum", {28'd0, out_sum}, 32'd12);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_sum", {28'd0, out_sum}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        tick();
        check("arst_hold_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        tick();
        expect_idle("arst_release");
        run_batch("post_arst", 4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 0);
        check("post_arst_sum", {28'd0, out_sum}, 32'd10);
        tick();

        // COUNT=1 instance: every accepted operand is a result
        b_in_valid = 1'b1;
        b_in_data  = 4'd9;
        tick();
        b_in_valid = 1'b0;
        check("c1_valid", {31'd0, b_out_valid}, 32'd1);
        check("c1_sum", {28'd0, b_out_sum}, 32'd9);
        check("c1_carry", {31'd0, b_out_carry}, 32'd0);
        check("c1_in_ready", {31'd0, b_in_ready}, 32'd0);
        tick();
        check("c1_handoff", {31'd0, b_out_valid}, 32'd0);
        check("c1_ready_again", {31'd0, b_in_ready}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = 4'(i);
            tick();
            b_in_valid = 1'b0;
            check("c1_gap_sum", {28'd0, b_out_sum}, 32'(i));
            check("c1_gap_valid", {31'd0, b_out_valid}, 32'd1);
            for (int g = 0; g < 3; g++) tick();
            check("c1_gap_idle", {31'd0, b_busy}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
